// File: rtl/usb_reg_bridge_if.sv
// Signal bundle between the SAM3U external-memory pads and the internal register bus.
// The bridge uses the slave view; the host/register side uses the master view.
interface usb_reg_bridge_if #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int BYTECNT_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0]    USB_Addr;
    logic [DATA_WIDTH-1:0]    USB_Din;
    logic [DATA_WIDTH-1:0]    USB_Dout;
    logic                     USB_Drive;
    logic                     USB_RDn;
    logic                     USB_WRn;
    logic                     USB_CEn;
    logic                     USB_ALEn;
    logic [ADDR_WIDTH-1:0]    reg_address;
    logic [BYTECNT_WIDTH-1:0] reg_bytecnt;
    logic [DATA_WIDTH-1:0]    reg_datao;
    logic [DATA_WIDTH-1:0]    reg_datai;
    logic                     reg_read;
    logic                     reg_write;
    logic                     reg_addrvalid;
    logic                     bus_err;

    modport slave (
        input  USB_Addr, USB_Din, USB_RDn, USB_WRn, USB_CEn, USB_ALEn, reg_datai,
        output USB_Dout, USB_Drive, reg_address, reg_bytecnt, reg_datao,
               reg_read, reg_write, reg_addrvalid, bus_err
    );

    modport master (
        output USB_Addr, USB_Din, USB_RDn, USB_WRn, USB_CEn, USB_ALEn, reg_datai,
        input  USB_Dout, USB_Drive, reg_address, reg_bytecnt, reg_datao,
               reg_read, reg_write, reg_addrvalid, bus_err
    );
endinterface

// File: rtl/usb_reg_bridge.sv
// SAM3U external-memory bus to internal register bus bridge: strobe synchronisation,
// address latching on ALEn, saturating burst byte counter, bus-error and idle-timeout tracking.
module usb_reg_bridge #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int BYTECNT_WIDTH = 7,
    parameter int TIMEOUT       = 1024
) (
    input  logic            clk_usb,
    input  logic            reset_i,
    usb_reg_bridge_if.slave bus
);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [BYTECNT_WIDTH-1:0] CNT_MAX  = {BYTECNT_WIDTH{1'b1}};
    localparam logic [BYTECNT_WIDTH-1:0] CNT_ONE  = {{(BYTECNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]          TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]          TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    logic rdn_s1_q, rdn_s2_q, rdn_s3_q;
    logic wrn_s1_q, wrn_s2_q, wrn_s3_q;
    logic cen_s1_q, cen_s2_q;
    logic alen_s1_q, alen_s2_q, alen_s3_q;
    logic [ADDR_WIDTH-1:0] addr_s1_q, addr_s2_q;
    logic [DATA_WIDTH-1:0] din_s1_q, din_s2_q;

    state_t                   state_q;
    logic [ADDR_WIDTH-1:0]    address_q;
    logic [BYTECNT_WIDTH-1:0] bytecnt_q;
    logic [BYTECNT_WIDTH-1:0] bytecnt_d;
    logic [DATA_WIDTH-1:0]    datao_q;
    logic [DATA_WIDTH-1:0]    dout_q;
    logic                     write_q;
    logic                     read_q;
    logic                     rd_cap_q;
    logic                     inc_pend_q;
    logic                     addrvalid_q;
    logic                     bus_err_q;
    logic [TO_W-1:0]          to_cnt_q;

    logic rd_fall_s, wr_fall_s, ale_fall_s, strobe_edge_s, conflict_s;

    // Two-flop synchronisers plus edge-detect stage; strobes preset inactive.
    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            rdn_s1_q  <= 1'b1; rdn_s2_q  <= 1'b1; rdn_s3_q  <= 1'b1;
            wrn_s1_q  <= 1'b1; wrn_s2_q  <= 1'b1; wrn_s3_q  <= 1'b1;
            cen_s1_q  <= 1'b1; cen_s2_q  <= 1'b1;
            alen_s1_q <= 1'b1; alen_s2_q <= 1'b1; alen_s3_q <= 1'b1;
            addr_s1_q <= {ADDR_WIDTH{1'b0}};
            addr_s2_q <= {ADDR_WIDTH{1'b0}};
            din_s1_q  <= {DATA_WIDTH{1'b0}};
            din_s2_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            rdn_s1_q  <= bus.USB_RDn;  rdn_s2_q  <= rdn_s1_q;  rdn_s3_q  <= rdn_s2_q;
            wrn_s1_q  <= bus.USB_WRn;  wrn_s2_q  <= wrn_s1_q;  wrn_s3_q  <= wrn_s2_q;
            cen_s1_q  <= bus.USB_CEn;  cen_s2_q  <= cen_s1_q;
            alen_s1_q <= bus.USB_ALEn; alen_s2_q <= alen_s1_q; alen_s3_q <= alen_s2_q;
            addr_s1_q <= bus.USB_Addr; addr_s2_q <= addr_s1_q;
            din_s1_q  <= bus.USB_Din;  din_s2_q  <= din_s1_q;
        end
    end

    assign rd_fall_s     = rdn_s3_q & ~rdn_s2_q;
    assign wr_fall_s     = wrn_s3_q & ~wrn_s2_q;
    assign ale_fall_s    = alen_s3_q & ~alen_s2_q;
    assign strobe_edge_s = (rdn_s3_q ^ rdn_s2_q) | (wrn_s3_q ^ wrn_s2_q);
    // A new strobe while the other one is already (or simultaneously) low is a host fault.
    assign conflict_s    = (rd_fall_s | wr_fall_s) & ~rdn_s2_q & ~wrn_s2_q;

    // Saturating increment of the burst byte index.
    always_comb begin
        bytecnt_d = bytecnt_q;
        if (bytecnt_q == CNT_MAX) begin
            bytecnt_d = bytecnt_q;
        end else begin
            bytecnt_d = bytecnt_q + CNT_ONE;
        end
    end

    // Bus FSM with registered register-bus outputs, byte counter and idle timeout.
    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            address_q   <= {ADDR_WIDTH{1'b0}};
            bytecnt_q   <= {BYTECNT_WIDTH{1'b0}};
            datao_q     <= {DATA_WIDTH{1'b0}};
            dout_q      <= {DATA_WIDTH{1'b0}};
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            rd_cap_q    <= 1'b0;
            inc_pend_q  <= 1'b0;
            addrvalid_q <= 1'b0;
            bus_err_q   <= 1'b0;
            to_cnt_q    <= {TO_W{1'b0}};
        end else begin
            write_q    <= 1'b0;
            read_q     <= 1'b0;
            inc_pend_q <= 1'b0;
            rd_cap_q   <= read_q;
            if (inc_pend_q) begin
                bytecnt_q <= bytecnt_d;
            end
            // Register block answers one cycle after the read pulse.
            if (rd_cap_q) begin
                dout_q <= bus.reg_datai;
            end
            case (state_q)
                ST_IDLE: begin
                    to_cnt_q <= {TO_W{1'b0}};
                    if (!cen_s2_q && ale_fall_s) begin
                        state_q   <= ST_ADDR;
                        address_q <= addr_s2_q;
                        bytecnt_q <= {BYTECNT_WIDTH{1'b0}};
                    end
                end
                ST_ADDR: begin
                    to_cnt_q <= {TO_W{1'b0}};
                    if (cen_s2_q) begin
                        state_q <= ST_IDLE;
                    end else if (alen_s2_q) begin
                        state_q     <= ST_ACTIVE;
                        addrvalid_q <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (cen_s2_q) begin
                        state_q     <= ST_IDLE;
                        addrvalid_q <= 1'b0;
                        to_cnt_q    <= {TO_W{1'b0}};
                    end else if (ale_fall_s) begin
                        state_q     <= ST_ADDR;
                        address_q   <= addr_s2_q;
                        bytecnt_q   <= {BYTECNT_WIDTH{1'b0}};
                        addrvalid_q <= 1'b0;
                        to_cnt_q    <= {TO_W{1'b0}};
                    end else if (conflict_s) begin
                        bus_err_q <= 1'b1;
                        to_cnt_q  <= {TO_W{1'b0}};
                    end else if (wr_fall_s) begin
                        write_q    <= 1'b1;
                        datao_q    <= din_s2_q;
                        inc_pend_q <= 1'b1;
                        to_cnt_q   <= {TO_W{1'b0}};
                    end else if (rd_fall_s) begin
                        read_q     <= 1'b1;
                        inc_pend_q <= 1'b1;
                        to_cnt_q   <= {TO_W{1'b0}};
                    end else if (strobe_edge_s) begin
                        to_cnt_q <= {TO_W{1'b0}};
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q     <= ST_IDLE;
                        addrvalid_q <= 1'b0;
                        to_cnt_q    <= {TO_W{1'b0}};
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_ONE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    addrvalid_q <= 1'b0;
                    to_cnt_q    <= {TO_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.USB_Dout      = dout_q;
    assign bus.USB_Drive     = ~cen_s2_q & ~rdn_s2_q & (state_q == ST_ACTIVE);
    assign bus.reg_address   = address_q;
    assign bus.reg_bytecnt   = bytecnt_q;
    assign bus.reg_datao     = datao_q;
    assign bus.reg_read      = read_q;
    assign bus.reg_write     = write_q;
    assign bus.reg_addrvalid = addrvalid_q;
    assign bus.bus_err       = bus_err_q;
endmodule

// File: tb/tb_usb_reg_bridge.sv
// Randomised scoreboard bench for usb_reg_bridge: host-side tasks push expected register
// accesses, a negedge monitor pops and compares them as the DUT pulses reg_write/reg_read.
module tb_usb_reg_bridge;
    logic clk_usb = 1'b0;
    logic reset_i;

    always #5 clk_usb = ~clk_usb;

    usb_reg_bridge_if bus ();

    usb_reg_bridge dut (
        .clk_usb (clk_usb),
        .reset_i (reset_i),
        .bus     (bus.slave)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [6:0] cnt;
        logic [7:0] data;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   dout_pend = 0;
    logic [7:0] dout_exp;

    // Reference state of the bus as the host sees it
    logic [7:0] m_addr;
    int         m_cnt;
    logic       m_valid;
    logic       m_err;
    logic [7:0] rd_base;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Register block stand-in: read data returned one cycle after the read pulse.
    always @(posedge clk_usb) begin
        if (bus.reg_read) bus.reg_datai <= rd_base + 8'(bus.reg_bytecnt);
    end

    // Monitor: pop expected accesses whenever the DUT pulses.
    always @(negedge clk_usb) begin
        if (dout_pend > 0) begin
            dout_pend--;
            if (dout_pend == 0) chk("usb_dout", 32'(bus.USB_Dout), 32'(dout_exp));
        end
        if (!reset_i && bus.reg_write) begin
            if (wq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_write: got pulse addr 0x%0h, expected none at %0t", bus.reg_address, $time);
            end else begin
                mon_e = wq.pop_front();
                chk("wr_addr", 32'(bus.reg_address), 32'(mon_e.addr));
                chk("wr_bytecnt", 32'(bus.reg_bytecnt), 32'(mon_e.cnt));
                chk("wr_data", 32'(bus.reg_datao), 32'(mon_e.data));
            end
        end
        if (!reset_i && bus.reg_read) begin
            if (rq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_read: got pulse addr 0x%0h, expected none at %0t", bus.reg_address, $time);
            end else begin
                mon_e = rq.pop_front();
                chk("rd_addr", 32'(bus.reg_address), 32'(mon_e.addr));
                chk("rd_bytecnt", 32'(bus.reg_bytecnt), 32'(mon_e.cnt));
                dout_exp  = mon_e.data;
                dout_pend = 2;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_usb);
    endtask

    task automatic open_burst(input logic [7:0] a);
        bus.USB_CEn  = 1'b0;
        bus.USB_Addr = a;
        cyc(1);
        bus.USB_ALEn = 1'b0;
        cyc(3);
        bus.USB_ALEn = 1'b1;
        cyc(4);
        m_addr = a; m_cnt = 0; m_valid = 1'b1;
        chk("addrvalid_open", 32'(bus.reg_addrvalid), 32'd1);
        chk("address_open", 32'(bus.reg_address), 32'(a));
        chk("bytecnt_open", 32'(bus.reg_bytecnt), 32'd0);
    endtask

    task automatic close_burst();
        bus.USB_CEn = 1'b1;
        cyc(4);
        m_valid = 1'b0;
        chk("addrvalid_close", 32'(bus.reg_addrvalid), 32'd0);
    endtask

    task automatic wr(input logic [7:0] d);
        exp_t e;
        bus.USB_Din = d;
        if (m_valid) begin
            e.addr = m_addr; e.cnt = 7'(m_cnt); e.data = d;
            wq.push_back(e);
        end
        bus.USB_WRn = 1'b0;
        cyc(3);
        chk("drive_during_write", 32'(bus.USB_Drive), 32'd0);
        cyc(2);
        bus.USB_WRn = 1'b1;
        cyc(4);
        if (m_valid && m_cnt < 127) m_cnt++;
    endtask

    task automatic rd();
        exp_t e;
        if (m_valid) begin
            e.addr = m_addr; e.cnt = 7'(m_cnt); e.data = rd_base + 8'(m_cnt);
            rq.push_back(e);
        end
        bus.USB_RDn = 1'b0;
        cyc(4);
        chk("drive_rd_low", 32'(bus.USB_Drive), 32'(m_valid));
        bus.USB_RDn = 1'b1;
        cyc(4);
        chk("drive_rd_high", 32'(bus.USB_Drive), 32'd0);
        if (m_valid && m_cnt < 127) m_cnt++;
    endtask

    task automatic conflict();
        bus.USB_RDn = 1'b0;
        bus.USB_WRn = 1'b0;
        cyc(5);
        bus.USB_RDn = 1'b1;
        bus.USB_WRn = 1'b1;
        cyc(4);
        if (m_valid) m_err = 1'b1;
        chk("bus_err_conflict", 32'(bus.bus_err), 32'(m_err));
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        cyc(1);
        chk("rst_address", 32'(bus.reg_address), 32'd0);
        chk("rst_bytecnt", 32'(bus.reg_bytecnt), 32'd0);
        chk("rst_datao", 32'(bus.reg_datao), 32'd0);
        chk("rst_read", 32'(bus.reg_read), 32'd0);
        chk("rst_write", 32'(bus.reg_write), 32'd0);
        chk("rst_addrvalid", 32'(bus.reg_addrvalid), 32'd0);
        chk("rst_bus_err", 32'(bus.bus_err), 32'd0);
        chk("rst_drive", 32'(bus.USB_Drive), 32'd0);
        chk("rst_dout", 32'(bus.USB_Dout), 32'd0);
        cyc(1);
        reset_i = 1'b0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected $finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.USB_Addr = 8'h00; bus.USB_Din = 8'h00;
        bus.USB_RDn = 1'b1; bus.USB_WRn = 1'b1; bus.USB_CEn = 1'b1; bus.USB_ALEn = 1'b1;
        rd_base = 8'hA0; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0; m_addr = 8'h00;
        reset_i = 1'b1;
        cyc(3);
        do_reset();

        // Three-byte write burst
        open_burst(8'h1A);
        wr(8'h11); wr(8'h22); wr(8'h33);
        chk("bytecnt_after_3", 32'(bus.reg_bytecnt), 32'd3);
        close_burst();

        // Four-byte read burst
        rd_base = 8'hA0;
        open_burst(8'h05);
        repeat (4) rd();
        close_burst();

        // Long write burst saturates the byte counter
        open_burst(8'(($urandom)));
        for (int i = 0; i < 130; i++) wr(8'($urandom));
        chk("bytecnt_saturated", 32'(bus.reg_bytecnt), 32'd127);
        close_burst();

        // Simultaneous strobes flag a sticky bus error
        open_burst(8'h42);
        wr(8'h5A);
        conflict();
        wr(8'hC3);
        rd();
        chk("bus_err_sticky", 32'(bus.bus_err), 32'd1);
        close_burst();
        chk("bus_err_after_close", 32'(bus.bus_err), 32'd1);

        // Idle timeout drops addrvalid; strobes ignored until a new address
        open_burst(8'h77);
        wr(8'h01);
        cyc(900);
        chk("addrvalid_before_timeout", 32'(bus.reg_addrvalid), 32'd1);
        cyc(200);
        m_valid = 1'b0;
        chk("addrvalid_after_timeout", 32'(bus.reg_addrvalid), 32'd0);
        wr(8'hEE);
        open_burst(8'h78);
        wr(8'h02);
        close_burst();

        // Reset in the middle of a burst, including a strobe held low across reset
        open_burst(8'h33);
        wr(8'h10); wr(8'h20); wr(8'h30);
        do_reset();
        bus.USB_CEn = 1'b1;
        bus.USB_WRn = 1'b0;
        reset_i = 1'b1;
        cyc(2);
        reset_i = 1'b0;
        cyc(6);
        bus.USB_WRn = 1'b1;
        cyc(4);
        open_burst(8'h33);
        wr(8'h40); wr(8'h50);
        close_burst();

        // Randomised mixed bursts
        for (int b = 0; b < 25; b++) begin
            rd_base = 8'($urandom);
            open_burst(8'($urandom));
            for (int k = 0; k < int'($urandom_range(1, 8)); k++) begin
                if ($urandom_range(0, 1) == 0) wr(8'($urandom));
                else rd();
                cyc(int'($urandom_range(0, 3)));
            end
            chk("rand_bytecnt", 32'(bus.reg_bytecnt), 32'(m_cnt));
            chk("rand_address", 32'(bus.reg_address), 32'(m_addr));
            close_burst();
        end

        cyc(10);
        chk("write_queue_drained", 32'(wq.size()), 32'd0);
        chk("read_queue_drained", 32'(rq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
